ring_load_sequencer: RTL and testbench

Controller that sequences the 8-bit parallel-load ring/shift register (`PLShift_reg` and its seven-segment variant). It accepts a pattern plus a step count over a valid/ready command port, drives the register's `load`/`en`/`Data` inputs to load the pattern, then rotates it for exactly the requested number of enabled cycles. Pause and abort are supported, and completion is signalled with a one-cycle `done`. It sits between the command source and the shift-register datapath.

---
 rtl/ring_seq_pkg.sv | 29 ++
 rtl/ring_step_counter.sv | 30 +++
 rtl/ring_load_sequencer.sv | 103 ++++++++++
 tb/tb_ring_load_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_seq_pkg.sv
// rtl/ring_seq_pkg.sv - shared state type, default sizes and rotate helper for the ring load sequencer
package ring_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STEP_W = 5;

    // Rotate the low w bits of v left by n places; bits above w are cleared.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned w,
                                         input int unsigned n);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        r    = v & mask;
        for (int i = 0; i < 64; i++) begin
            if (i < n) begin
                r = ((r << 1) | ((r >> (w - 1)) & 64'd1)) & mask;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_step_counter.sv
// rtl/ring_step_counter.sv - loadable down-counter holding the remaining rotation count
module ring_step_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         clear,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_next
);

    // Flags the edge on which the count reaches zero through a decrement.
    assign zero_next = dec & (count == W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/ring_load_sequencer.sv
// rtl/ring_load_sequencer.sv - loads a pattern into the ring shift register and rotates it N enabled cycles
module ring_load_sequencer
    import ring_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_pattern,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              pause,
    input  logic              abort,
    output logic              sr_load,
    output logic              sr_en,
    output logic [WIDTH-1:0]  sr_data,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic [WIDTH-1:0]  exp_q
);

    seq_state_t state;
    seq_state_t state_next;
    logic       handshake;
    logic       rotate;
    logic       last_step;

    assign cmd_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy      = (state == ST_LOAD) || (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign sr_load   = (state == ST_LOAD);
    assign sr_en     = (state == ST_LOAD) || ((state == ST_RUN) && !pause);

    // Abort wins over a same-cycle handshake and over a pending rotation.
    assign handshake = cmd_valid & cmd_ready & ~abort;
    assign rotate    = (state == ST_RUN) & sr_en & ~abort;

    ring_step_counter #(
        .W(STEP_W)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (handshake),
        .load_value (cmd_steps),
        .clear      (abort),
        .dec        (rotate),
        .count      (steps_left),
        .zero_next  (last_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = (steps_left != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = handshake ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // exp_q mirrors the external register: loaded with the pattern, rotated on each RUN enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_data <= '0;
            exp_q   <= '0;
        end else if (handshake) begin
            sr_data <= cmd_pattern;
            exp_q   <= cmd_pattern;
        end else if (rotate) begin
            exp_q   <= WIDTH'(rotl(64'(exp_q), WIDTH, 1));
        end
    end

endmodule

// File: tb/tb_ring_load_sequencer.sv
// tb/tb_ring_load_sequencer.sv - scoreboard bench for ring_load_sequencer with a behavioural shift register
module tb_ring_load_sequencer;
    import ring_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_pattern = 8'h00;
    logic [4:0] cmd_steps = 5'd0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic       sr_load;
    logic       sr_en;
    logic [7:0] sr_data;
    logic       busy;
    logic       done;
    logic [4:0] steps_left;
    logic [7:0] exp_q;

    ring_load_sequencer #(.WIDTH(8), .STEP_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_pattern (cmd_pattern),
        .cmd_steps   (cmd_steps),
        .pause       (pause),
        .abort       (abort),
        .sr_load     (sr_load),
        .sr_en       (sr_en),
        .sr_data     (sr_data),
        .busy        (busy),
        .done        (done),
        .steps_left  (steps_left),
        .exp_q       (exp_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   load_cnt = 0;
    logic [7:0] tb_q = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the PLShift_reg datapath.
    always @(posedge clk) begin
        if (sr_en) tb_q <= sr_load ? sr_data : {tb_q[6:0], tb_q[7]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Spec cycle numbering: the cycle after handshake edge t is cycle t+1, so it is cyc+1 here.
    always @(negedge clk) begin
        if (!rst) begin
            en_cnt   += int'(sr_en);
            load_cnt += int'(sr_load);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_exp_q", 32'(exp_q), 32'(e.q));
                    chk("done_reg_q", 32'(tb_q), 32'(e.q));
                    chk("done_cycle", 32'(cyc + 1), 32'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input logic [7:0] p, input logic [4:0] n, input int pauses,
                         output int t);
        chk("ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_pattern = p;
        cmd_steps   = n;
        @(posedge clk);
        #1;
        t = cyc;
        cmd_valid = 1'b0;
        sb.push_back('{q: 8'(rotl(64'(p), 8, n)), cyc: t + 2 + int'(n) + pauses});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int e0;
        int l0;

        #1 rst = 1'b1;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_sr_load", 32'(sr_load), 32'd0);
        chk("rst_sr_en", 32'(sr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_steps_left", 32'(steps_left), 32'd0);
        chk("rst_exp_q", 32'(exp_q), 32'd0);
        chk("rst_sr_data", 32'(sr_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8'h07 rotated 3 -> 8'h38, done at t+5
        e0 = en_cnt;
        l0 = load_cnt;
        issue(8'h07, 5'd3, 0, t);
        chk("t1_busy_in_load", 32'(busy), 32'd1);
        chk("t1_cmd_ready_in_load", 32'(cmd_ready), 32'd0);
        drain("t1_drain");
        chk("t1_en_cycles", 32'(en_cnt - e0), 32'd4);
        chk("t1_load_cycles", 32'(load_cnt - l0), 32'd1);

        // load only: done at t+2, a single enable cycle
        e0 = en_cnt;
        issue(8'hA5, 5'd0, 0, t);
        drain("t2_drain");
        chk("t2_en_cycles", 32'(en_cnt - e0), 32'd1);

        // 8'h81 rotated 4 -> 8'h18 with two pause cycles, done at t+8
        issue(8'h81, 5'd4, 2, t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t3_sl_before_pause", 32'(steps_left), 32'd3);
        pause = 1'b1;
        #0;
        chk("t3_sr_en_paused", 32'(sr_en), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_sl_frozen_1", 32'(steps_left), 32'd3);
        @(posedge clk);
        #1;
        chk("t3_sl_frozen_2", 32'(steps_left), 32'd3);
        pause = 1'b0;
        drain("t3_drain");

        // back-to-back: 8'h01/2 then 8'h02/1 taken in DONE, second done at t+7
        cmd_valid   = 1'b1;
        cmd_pattern = 8'h01;
        cmd_steps   = 5'd2;
        @(posedge clk);
        #1;
        t = cyc;
        sb.push_back('{q: 8'h04, cyc: t + 4});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("t4_in_done_ready", 32'(cmd_ready), 32'd1);
        cmd_pattern = 8'h02;
        cmd_steps   = 5'd1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("t4_b2b_load", 32'(sr_load), 32'd1);
        chk("t4_b2b_sr_data", 32'(sr_data), 32'h02);
        sb.push_back('{q: 8'h04, cyc: t + 4 + 3});
        drain("t4_drain");
        chk("t4_final_exp_q", 32'(exp_q), 32'h04);

        // abort in RUN at steps_left=5, with a same-cycle command offered
        issue(8'h3C, 5'd9, 0, t);
        void'(sb.pop_back());
        for (int i = 0; i < 20; i++) begin
            if (steps_left == 5'd5) break;
            @(posedge clk);
            #1;
        end
        chk("t5_reach_sl5", 32'(steps_left), 32'd5);
        abort       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_pattern = 8'h55;
        cmd_steps   = 5'd1;
        @(posedge clk);
        #1;
        chk("t5_idle_after_abort", 32'(busy), 32'd0);
        chk("t5_ready_after_abort", 32'(cmd_ready), 32'd1);
        chk("t5_sl_cleared", 32'(steps_left), 32'd0);
        chk("t5_exp_q_held", 32'(exp_q), 32'hC3);
        @(posedge clk);
        #1;
        chk("t5_no_accept_busy", 32'(busy), 32'd0);
        chk("t5_no_accept_data", 32'(sr_data), 32'h3C);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset mid-RUN, then 8'hFF/8 completes with 8'hFF
        issue(8'h0F, 5'd6, 0, t);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        chk("t6_in_run", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_sr_en", 32'(sr_en), 32'd0);
        chk("t6_async_ready", 32'(cmd_ready), 32'd1);
        chk("t6_async_sl", 32'(steps_left), 32'd0);
        chk("t6_async_exp_q", 32'(exp_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(8'hFF, 5'd8, 0, t);
        drain("t6_drain");
        chk("t6_final_exp_q", 32'(exp_q), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
